// File: rtl/ofm_writer_pkg.sv
// Shared definitions for the output feature map write controller.
package ofm_writer_pkg;

    localparam int WORD_W = 32;
    localparam int ADR_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/ofm_writer_if.sv
// Result stream (valid/ready) plus memory write port of the OFM writer.
interface ofm_writer_if;
    import ofm_writer_pkg::*;

    logic              s_valid;
    logic [WORD_W-1:0] s_data;
    logic              s_ready;
    logic [ADR_W-1:0]  ofm_adr;
    logic [WORD_W-1:0] ofm_in;
    logic              ofm_we;

    modport master (
        output s_valid, s_data,
        input  s_ready, ofm_adr, ofm_in, ofm_we
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, ofm_adr, ofm_in, ofm_we
    );

endinterface

// File: rtl/ofm_wr_fifo.sv
// Small synchronous skid FIFO between the result stream and the write port.
module ofm_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer MSB tells full (wrapped once) from empty (same lap).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ofm_writer.sv
// Writes a stream of accumulator results into the OFM memory in
// channel -> row -> column order, with optional ReLU and a level done flag.
module ofm_writer
    import ofm_writer_pkg::*;
#(
    parameter int OUT_W      = 8,
    parameter int OUT_H      = 8,
    parameter int OUT_C      = 4,
    parameter int ROW_PITCH  = OUT_W,
    parameter int CH_PITCH   = OUT_H * ROW_PITCH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ADR_W-1:0] base_adr,
    input  logic             relu_en,
    ofm_writer_if.slave      bus,
    output logic             done
);

    localparam logic [31:0]      N_WORDS  = 32'(OUT_W * OUT_H * OUT_C);
    localparam logic [31:0]      X_LAST   = 32'(OUT_W - 1);
    localparam logic [31:0]      R_LAST   = 32'(OUT_H - 1);
    localparam logic [ADR_W-1:0] ROW_STEP = ADR_W'(ROW_PITCH);
    localparam logic [ADR_W-1:0] CH_STEP  = ADR_W'(CH_PITCH);

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       accepted;
    logic [31:0]       written;
    logic [31:0]       x;
    logic [31:0]       r;
    logic [31:0]       c;
    logic [ADR_W-1:0]  cur_adr;
    logic [ADR_W-1:0]  row_adr;
    logic [ADR_W-1:0]  ch_adr;
    logic              relu_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_rdata;
    logic              push;
    logic              pop;
    logic              begin_map;

    assign begin_map   = start && ((state == IDLE) || (state == DONE));
    assign bus.s_ready = (state == RUN) && !fifo_full && (accepted < N_WORDS);
    assign push        = bus.s_valid && bus.s_ready;
    assign pop         = ((state == RUN) || (state == DRAIN)) && !fifo_empty;
    assign done        = (state == DONE);

    ofm_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (bus.s_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN:        if (push && (accepted == N_WORDS - 32'd1)) state_nxt = DRAIN;
            DRAIN:      if (fifo_empty && (written == N_WORDS)) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Row/channel start addresses are kept so each step is a single add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accepted <= '0;
            written  <= '0;
            x        <= '0;
            r        <= '0;
            c        <= '0;
            cur_adr  <= '0;
            row_adr  <= '0;
            ch_adr   <= '0;
            relu_q   <= 1'b0;
        end else if (begin_map) begin
            accepted <= '0;
            written  <= '0;
            x        <= '0;
            r        <= '0;
            c        <= '0;
            cur_adr  <= base_adr;
            row_adr  <= base_adr;
            ch_adr   <= base_adr;
            relu_q   <= relu_en;
        end else begin
            if (push)
                accepted <= accepted + 32'd1;
            if (pop) begin
                written <= written + 32'd1;
                if (x == X_LAST) begin
                    x <= '0;
                    if (r == R_LAST) begin
                        r       <= '0;
                        c       <= c + 32'd1;
                        ch_adr  <= ch_adr + CH_STEP;
                        row_adr <= ch_adr + CH_STEP;
                        cur_adr <= ch_adr + CH_STEP;
                    end else begin
                        r       <= r + 32'd1;
                        row_adr <= row_adr + ROW_STEP;
                        cur_adr <= row_adr + ROW_STEP;
                    end
                end else begin
                    x       <= x + 32'd1;
                    cur_adr <= cur_adr + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ofm_we  <= 1'b0;
            bus.ofm_adr <= '0;
            bus.ofm_in  <= '0;
        end else begin
            bus.ofm_we <= pop;
            if (pop) begin
                bus.ofm_adr <= cur_adr;
                bus.ofm_in  <= (relu_q && fifo_rdata[WORD_W-1]) ? '0 : fifo_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ofm_writer.sv
// Bench for ofm_writer: two 2x2x2 instances (default and widened pitches) driven in lockstep.
module tb_ofm_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_adr = '0;
    logic        relu_en = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        done_a;
    logic        done_b;

    ofm_writer_if ifa ();
    ofm_writer_if ifb ();

    assign ifa.s_valid = s_valid;
    assign ifa.s_data  = s_data;
    assign ifb.s_valid = s_valid;
    assign ifb.s_data  = s_data;

    ofm_writer #(.OUT_W(2), .OUT_H(2), .OUT_C(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr),
        .relu_en(relu_en), .bus(ifa), .done(done_a)
    );

    ofm_writer #(.OUT_W(2), .OUT_H(2), .OUT_C(2), .ROW_PITCH(4), .CH_PITCH(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr),
        .relu_en(relu_en), .bus(ifb), .done(done_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] cap_adr_a[$];
    logic [31:0] cap_in_a[$];
    logic [31:0] cap_adr_b[$];
    logic [31:0] cap_in_b[$];
    int          we_cyc_a[$];
    int          done_rise_a = -1;
    logic        done_prev_a = 1'b0;
    int          first_acc = 0;

    always @(negedge clk) begin
        if (ifa.ofm_we) begin
            cap_adr_a.push_back(ifa.ofm_adr);
            cap_in_a.push_back(ifa.ofm_in);
            we_cyc_a.push_back(cyc);
        end
        if (ifb.ofm_we) begin
            cap_adr_b.push_back(ifb.ofm_adr);
            cap_in_b.push_back(ifb.ofm_in);
        end
        if (done_a && !done_prev_a)
            done_rise_a = cyc;
        done_prev_a = done_a;
    end

    int n_compared = 0;
    int n_mismatched = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: element i of a 2x2x2 map, channel-major.
    function automatic logic [31:0] model_adr(input logic [31:0] base, input int rp, input int cp, input int i);
        return base + 32'((i / 4) * cp + ((i / 2) % 2) * rp + (i % 2));
    endfunction

    function automatic logic [31:0] model_in(input logic [31:0] d, input logic relu);
        return (relu && $signed(d) < 0) ? 32'd0 : d;
    endfunction

    function automatic logic [7:0][31:0] mk8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        logic [7:0][31:0] v;
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
        return v;
    endfunction

    task automatic clear_capture();
        cap_adr_a.delete();
        cap_in_a.delete();
        cap_adr_b.delete();
        cap_in_b.delete();
        we_cyc_a.delete();
        done_rise_a = -1;
    endtask

    task automatic apply_stimulus(input logic [31:0] base, input logic relu, input logic [7:0][31:0] data,
                                  input bit gaps, input bit mid_start, input bit expect_done);
        int  idx;
        int  guard;
        bit  hs;
        bit  pulsed;
        logic was_done;
        clear_capture();
        was_done = done_a;
        if (expect_done)
            check_output("done_before_start", 32'(was_done), 32'd1);
        start = 1'b1;
        base_adr = base;
        relu_en = relu;
        @(posedge clk); #1;
        start = 1'b0;
        if (expect_done)
            check_output("done_fall_after_start", 32'(done_a), 32'd0);
        idx = 0;
        guard = 0;
        pulsed = 0;
        while (idx < 8 && guard < 200) begin
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data = data[idx];
            if (mid_start && idx == 3 && !pulsed) begin
                start = 1'b1;
                base_adr = $urandom;
                relu_en = !relu;
                pulsed = 1;
            end
            hs = s_valid && ifa.s_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (hs) begin
                if (idx == 0)
                    first_acc = cyc;
                idx++;
            end
            guard++;
        end
        if (idx < 8)
            check_output("accept_timeout", 32'(idx), 32'd8);
        s_valid = 1'b1;
        s_data = 32'hdead_beef;
        check_output("ready_low_after_n", 32'(ifa.s_ready), 32'd0);
        guard = 0;
        while (!(done_a && done_b) && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        s_valid = 1'b0;
        check_output("done_level", 32'(done_a && done_b), 32'd1);
        @(negedge clk); #1;
    endtask

    task automatic check_map(input string tag, input logic [7:0][31:0] exp_a, input logic [7:0][31:0] exp_b,
                             input logic [7:0][31:0] exp_in, input bit back_to_back);
        check_output({tag, " count_a"}, 32'(cap_adr_a.size()), 32'd8);
        check_output({tag, " count_b"}, 32'(cap_adr_b.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < cap_adr_a.size()) begin
                check_output($sformatf("%s adr_a[%0d]", tag, i), cap_adr_a[i], exp_a[i]);
                check_output($sformatf("%s in_a[%0d]", tag, i), cap_in_a[i], exp_in[i]);
            end
            if (i < cap_adr_b.size()) begin
                check_output($sformatf("%s adr_b[%0d]", tag, i), cap_adr_b[i], exp_b[i]);
                check_output($sformatf("%s in_b[%0d]", tag, i), cap_in_b[i], exp_in[i]);
            end
        end
        if (we_cyc_a.size() == 8) begin
            check_output({tag, " first_latency"}, 32'(we_cyc_a[0]), 32'(first_acc + 1));
            check_output({tag, " done_rise"}, 32'(done_rise_a), 32'(we_cyc_a[7] + 1));
            if (back_to_back)
                check_output({tag, " we_span"}, 32'(we_cyc_a[7] - we_cyc_a[0]), 32'd7);
        end
    endtask

    typedef struct packed {
        logic [31:0]      base;
        logic             relu;
        logic [7:0][31:0] data;
        logic [7:0][31:0] adr_a;
        logic [7:0][31:0] adr_b;
        logic [7:0][31:0] din;
    } vec_t;

    initial begin
        vec_t vecs[4];
        logic [7:0][31:0] rdata;
        logic [7:0][31:0] ea;
        logic [7:0][31:0] eb;
        logic [7:0][31:0] ei;
        logic [31:0] rbase;
        logic rrelu;
        int guard;

        vecs[0] = '{32'd0, 1'b0, mk8(1, 2, 3, 4, 5, 6, 7, 8),
                    mk8(0, 1, 2, 3, 4, 5, 6, 7), mk8(0, 1, 4, 5, 16, 17, 20, 21),
                    mk8(1, 2, 3, 4, 5, 6, 7, 8)};
        vecs[1] = '{32'd100, 1'b0, mk8(1, 2, 3, 4, 5, 6, 7, 8),
                    mk8(100, 101, 102, 103, 104, 105, 106, 107),
                    mk8(100, 101, 104, 105, 116, 117, 120, 121),
                    mk8(1, 2, 3, 4, 5, 6, 7, 8)};
        vecs[2] = '{32'h40, 1'b1,
                    mk8(32'hffff_fffb, 7, 32'h8000_0000, 3, 32'hffff_ffff, 32'h7fff_ffff, 0, 32'hffff_fff0),
                    mk8(64, 65, 66, 67, 68, 69, 70, 71), mk8(64, 65, 68, 69, 80, 81, 84, 85),
                    mk8(0, 7, 0, 3, 0, 32'h7fff_ffff, 0, 0)};
        vecs[3] = '{32'hffff_fffc, 1'b0,
                    mk8(32'hffff_fffb, 7, 32'h8000_0000, 3, 32'hffff_ffff, 32'h7fff_ffff, 0, 32'hffff_fff0),
                    mk8(32'hffff_fffc, 32'hffff_fffd, 32'hffff_fffe, 32'hffff_ffff, 0, 1, 2, 3),
                    mk8(32'hffff_fffc, 32'hffff_fffd, 0, 1, 12, 13, 16, 17),
                    mk8(32'hffff_fffb, 7, 32'h8000_0000, 3, 32'hffff_ffff, 32'h7fff_ffff, 0, 32'hffff_fff0)};

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset s_ready", 32'(ifa.s_ready), 32'd0);
        check_output("reset ofm_we", 32'(ifa.ofm_we), 32'd0);
        check_output("reset ofm_adr", ifa.ofm_adr, 32'd0);
        check_output("reset ofm_in", ifa.ofm_in, 32'd0);
        check_output("reset done", 32'(done_a), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b1;
        check_output("idle s_ready", 32'(ifa.s_ready), 32'd0);
        s_valid = 1'b0;

        for (int v = 0; v < 4; v++) begin
            apply_stimulus(vecs[v].base, vecs[v].relu, vecs[v].data, 1'b0, 1'b0, v != 0);
            check_map($sformatf("vec%0d", v), vecs[v].adr_a, vecs[v].adr_b, vecs[v].din, 1'b1);
        end

        for (int k = 0; k < 6; k++) begin
            rbase = $urandom;
            rrelu = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) begin
                rdata[i] = $urandom;
                ea[i] = model_adr(rbase, 2, 4, i);
                eb[i] = model_adr(rbase, 4, 16, i);
                ei[i] = model_in(rdata[i], rrelu);
            end
            apply_stimulus(rbase, rrelu, rdata, 1'b1, k % 2 == 0, 1'b1);
            check_map($sformatf("rand%0d", k), ea, eb, ei, 1'b0);
        end

        clear_capture();
        start = 1'b1;
        base_adr = 32'h200;
        relu_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        s_valid = 1'b1;
        s_data = 32'h55;
        guard = 0;
        while (cap_adr_a.size() < 3 && guard < 40) begin
            @(negedge clk); #1;
            guard++;
        end
        check_output("partial writes", 32'(cap_adr_a.size()), 32'd3);
        if (cap_adr_a.size() >= 3)
            check_output("partial adr[2]", cap_adr_a[2], 32'h202);
        rst_n = 1'b0;
        #1;
        check_output("midreset ofm_we", 32'(ifa.ofm_we), 32'd0);
        check_output("midreset ofm_adr", ifa.ofm_adr, 32'd0);
        check_output("midreset ofm_in", ifa.ofm_in, 32'd0);
        check_output("midreset s_ready", 32'(ifa.s_ready), 32'd0);
        check_output("midreset ofm_we_b", 32'(ifb.ofm_we), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("no writes after reset", 32'(cap_adr_a.size()), 32'd3);
        check_output("idle after reset done", 32'(done_a), 32'd0);
        s_valid = 1'b0;
        apply_stimulus(32'h200, 1'b0, vecs[0].data, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            ea[i] = model_adr(32'h200, 2, 4, i);
            eb[i] = model_adr(32'h200, 4, 16, i);
            ei[i] = model_in(vecs[0].data[i], 1'b0);
        end
        check_map("after_reset", ea, eb, ei, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check_output("done holds", 32'(done_a), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ofm_writer.md
# ofm_writer

Write-side controller that sits directly upstream of the output feature map memory. Accepts a stream of signed 32-bit results from the accumulator stage over a valid/ready handshake, optionally applies ReLU, and generates the memory's `adr`/`in`/`we` write port in channel → row → column order with configurable pitches. Raises a level `done` once the last word of the map is written; the memory's dump logic waits on that level.

## Interface
- `OUT_W`, default 8: output columns per row.
- `OUT_H`, default 8: output rows per channel.
- `OUT_C`, default 4: output channels; word count `N = OUT_W*OUT_H*OUT_C`.
- `ROW_PITCH`, default `OUT_W`: address step between rows, must be ≥ `OUT_W`.
- `CH_PITCH`, default `OUT_H*ROW_PITCH`: address step between channels, must be ≥ `OUT_H*ROW_PITCH`.
- `FIFO_DEPTH`, default 4: input skid FIFO depth, power of two.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse that begins a map; `base_adr` and `relu_en` are sampled on it.
- `base_adr`  in  32  address of element (c=0, r=0, x=0).
- `relu_en`  in  1  1: negative results are written as 0.
- `s_valid`  in  1  result word valid.
- `s_data`  in  32  signed result.
- `s_ready`  out  1  block accepts `s_data` this cycle.
- `ofm_adr`  out  32  memory write address.
- `ofm_in`  out  32  memory write data.
- `ofm_we`  out  1  memory write enable.
- `done`  out  1  level; map fully written.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`: clear counters and `done`, latch `base_adr`/`relu_en`.
  - RUN → DRAIN when the N-th word is accepted.
  - DRAIN → DONE when the FIFO is empty and the last write has issued.
  - DONE → RUN on `start`, with the same actions as from IDLE.
- `s_ready = (state==RUN) && !fifo_full && (accepted < N)`. A transfer occurs when `s_valid && s_ready`.
- Write side: in RUN or DRAIN, if the FIFO is not empty, pop one word per cycle and issue one write.
- Address counters `x`, `r`, `c` advance once per write.
  - `x` wraps at `OUT_W-1` and increments `r`.
  - `r` wraps at `OUT_H-1` and increments `c`.
  - `ofm_adr = base + c*CH_PITCH + r*ROW_PITCH + x`, built incrementally with adders only (no multipliers); modulo 2^32.
- `ofm_in = (relu_en && s_data[31]) ? 0 : s_data`. No other arithmetic on the data.
- `start` while in RUN or DRAIN is ignored.
- `s_valid` outside RUN is ignored; nothing is accepted.

## Timing
- Reset values: `s_ready=0`, `ofm_we=0`, `ofm_adr=0`, `ofm_in=0`, `done=0`; FSM in IDLE; FIFO empty; counters 0.
- `ofm_adr`, `ofm_in` and `ofm_we` are registered outputs. A word accepted at edge k with the FIFO empty is written (`ofm_we=1`) in the cycle after edge k+1: 2-cycle latency.
- With continuous `s_valid`, throughput is 1 write per cycle. `s_ready` is first high the cycle after the `start` edge.
- Simultaneous push and pop on a full FIFO is not allowed: `s_ready` is low when full.
- Simultaneous push and pop on an empty FIFO: the word passes through with normal latency.
- `done` rises one cycle after the last `ofm_we` cycle. It stays high until the next `start` edge, and falls in the cycle after that edge.
- `ofm_we` is never high for more than N cycles per map.
- Reset asserted mid-map: all state and outputs return to reset values immediately. Partial writes already issued remain in memory; nothing further is written.

## Structure
- The shared package holds `WORD_W=32`, the FSM state enum, and the address-width constant.
- Sub-module `ofm_wr_fifo`: synchronous FIFO with `FIFO_DEPTH` entries, full/empty flags and async active-low reset.
- FSM, counters and ReLU stay in the top module.

## Test plan
- 2×2×2 map, `base_adr=0`, pitches default, `s_valid` held high, data 1..8 → writes to adr 0..7 with data 1..8, 8 consecutive `ofm_we` cycles, `done` one cycle after.
- `ROW_PITCH=4`, `CH_PITCH=16`, 2×2×2 map, `base_adr=100` → write addresses 100, 101, 104, 105, 116, 117, 120, 121.
- `relu_en=1`, data −5, 7, 0x80000000, 3 → written 0, 7, 0, 3. With `relu_en=0` the same data is written unchanged.
- Random `s_valid` gaps plus `start` pulsed mid-RUN → `start` ignored; all N words written in order; `s_ready` low while the FIFO is full and after N words are accepted.
- Reset asserted after 3 of 8 writes → outputs at reset values next cycle, no further `ofm_we`. A new `start` then rewrites the full map from the base address.
- Second `start` in DONE → `done` drops one cycle after the `start` edge; the new base address is used; `done` rises again after N writes.
